switch_allocator: RTL
=====================

Name: switch_allocator

Overview:
- Per-cycle separable (input-first) switch allocator for the router crossbar.
- Each input port nominates one ready VC. Each output port then grants one nominating input.
- Winners drive buffer read selects and crossbar selects.
- Tracks downstream buffer credits per output port per downstream VC, so no flit is sent without space.

Parameters:
- PORT_NUM, 5, number of router ports (taken from noc_params).
- VC_NUM, 2, VCs per port (taken from noc_params).
- BUFFER_SIZE, 8, downstream input buffer depth per VC; the credit counter reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- request_i  in  [PORT_NUM][VC_NUM]  VC is non-empty and holds a VC allocation.
- out_port_i  in  [PORT_NUM][VC_NUM] x port_t  routed output port of each VC.
- downstream_vc_i  in  [PORT_NUM][VC_NUM] x VC_SIZE  allocated downstream VC of each VC.
- credit_i  in  [PORT_NUM][VC_NUM]  one credit returned from downstream for output port p, VC v.
- vc_sel_o  out  [PORT_NUM] x VC_SIZE  VC to read at each input port.
- read_o  out  [PORT_NUM]  input port p pops vc_sel_o[p] this cycle.
- xbar_sel_o  out  [PORT_NUM] x PORT_SIZE  input port connected to each output port.
- valid_o  out  [PORT_NUM]  output port p carries a valid flit this cycle.

Behaviour:
- Outputs are combinational from the inputs and registered state. While rst is high, all outputs are 0.
- State: the credit counters, the input round-robin pointers and the output round-robin pointers.
- Reset values: credit[p][v] = BUFFER_SIZE; all pointers = 0.
- Eligibility: a VC (i,v) is eligible when request_i[i][v] is set and credit[out_port_i[i][v]][downstream_vc_i[i][v]] > 0.
- Stage 1 (input arbitration): per input i, round-robin over eligible VCs starting at in_ptr[i] gives winner w_i.
- Stage 2 (output arbitration): per output o, round-robin over inputs whose w_i targets o, starting at out_ptr[o].
- Grant outputs for a stage-2 winner i at output o, in the same cycle as the request (zero-cycle latency):
  - read_o[i] = 1 and vc_sel_o[i] = w_i.
  - xbar_sel_o[o] = i and valid_o[o] = 1.
- Non-granted ports: read_o = 0, valid_o = 0. vc_sel_o and xbar_sel_o hold the value 0.
- Pointer update happens only on a full grant:
  - in_ptr[i] <= w_i + 1 mod VC_NUM.
  - out_ptr[o] <= i + 1 mod PORT_NUM.
  - An input that loses stage 2 keeps its pointer (iSLIP-style), which prevents starvation.
- Credit update per (o,d) each cycle: decrement on a grant using (o,d); increment on credit_i[o][d].
  - Both in the same cycle: the counter is unchanged.
- Credit bounds:
  - The counter never goes below 0, guaranteed by eligibility.
  - An increment at BUFFER_SIZE is a protocol error. The counter saturates and a simulation assertion fires.
- Port_t values outside 0..PORT_NUM-1 make the VC ineligible.
- Reset asserted mid-operation: all state returns to reset values on the next edge. In-flight credits are discarded, because the whole network resets together.
- No combinational path from credit_i to the outputs within the same cycle. Credits affect eligibility from the next cycle only.

Decomposition:
- Shared package noc_params holds PORT_NUM, VC_NUM, VC_SIZE, PORT_SIZE, port_t and BUFFER_SIZE default.
- No new typedefs are needed.
- One sub-module: round_robin_arbiter #(N).
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded index and any-grant flag.
  - Purely combinational.
- switch_allocator instantiates PORT_NUM input arbiters (N=VC_NUM) and PORT_NUM output arbiters (N=PORT_NUM). It owns all pointer and credit registers.

Test Plan:
- Single request: after reset, request_i[0][1]=1 targeting output 2, downstream VC 0 -> same cycle read_o[0]=1, vc_sel_o[0]=1, xbar_sel_o[2]=0, valid_o[2]=1. Next cycle credit[2][0]=7.
- Output contention: inputs 0, 1 and 3 all target output 4 continuously with credits refilled each cycle -> grants rotate 0,1,3,0,...; each input is served once per 3 cycles.
- Input VC rotation: input 2 with both VCs requesting different outputs, no contention -> vc_sel_o[2] alternates 0,1,0,1.
- Credit exhaustion: 8 consecutive grants to output 1, VC 0 with no credit_i -> 9th cycle valid_o[1]=0. One credit_i[1][0] pulse -> next cycle grant resumes.
- Simultaneous grant and credit: counter at 3; grant and credit_i on the same (o,d) in the same cycle -> counter remains 3.
- Reset mid-traffic: rst high for 1 cycle with counters partly drained -> outputs 0 during rst; afterwards counters = 8 and pointers = 0, so the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/noc_params.sv
// Router-wide NoC parameters shared by the switch allocator.
// Port and VC index widths are derived from the counts.
package noc_params;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM = 2;
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int BUFFER_SIZE = 8;

  typedef logic [PORT_SIZE-1:0] port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and wraps at N.
module round_robin_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!valid && request[j]) begin
        valid = 1'b1;
        grant[j] = 1'b1;
        index = j;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with
// per-output, per-downstream-VC credit tracking.
module switch_allocator
  import noc_params::*;
#(
  parameter int BUF_DEPTH = BUFFER_SIZE
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]        request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]       out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]        credit_i,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0]       vc_sel_o,
  output logic [PORT_NUM-1:0]                    read_o,
  output port_t [PORT_NUM-1:0]                   xbar_sel_o,
  output logic [PORT_NUM-1:0]                    valid_o
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [CW-1:0] credit [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0] in_ptr [PORT_NUM];
  port_t out_ptr [PORT_NUM];

  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic [PORT_NUM-1:0][VC_NUM-1:0] win_oh;
  logic [VC_SIZE-1:0] win [PORT_NUM];
  logic [PORT_NUM-1:0] win_valid;
  port_t tgt [PORT_NUM];
  logic [VC_SIZE-1:0] dvc [PORT_NUM];

  logic [PORT_NUM-1:0][PORT_NUM-1:0] out_req;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] g_oh;
  port_t g_idx [PORT_NUM];
  logic [PORT_NUM-1:0] g_valid;
  logic [PORT_NUM-1:0] granted;
  logic [PORT_NUM-1:0][VC_NUM-1:0] dec;

  // Out-of-range ports never match any o, so they stay ineligible
  always_comb begin
    elig = '0;
    for (int i = 0; i < PORT_NUM; i++)
      for (int v = 0; v < VC_NUM; v++)
        for (int o = 0; o < PORT_NUM; o++)
          if (request_i[i][v]
              && out_port_i[i][v] == port_t'(o)
              && credit[o][downstream_vc_i[i][v]] != '0)
            elig[i][v] = 1'b1;
  end

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
    round_robin_arbiter #(.N(VC_NUM), .IW(VC_SIZE)) u_arb (
      .request(elig[i]),
      .ptr(in_ptr[i]),
      .grant(win_oh[i]),
      .index(win[i]),
      .valid(win_valid[i])
    );
  end

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      tgt[i] = '0;
      dvc[i] = '0;
      for (int v = 0; v < VC_NUM; v++)
        if (win_oh[i][v]) begin
          tgt[i] = out_port_i[i][v];
          dvc[i] = downstream_vc_i[i][v];
        end
    end
  end

  always_comb begin
    out_req = '0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int i = 0; i < PORT_NUM; i++)
        out_req[o][i] = win_valid[i] && tgt[i] == port_t'(o);
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    round_robin_arbiter #(.N(PORT_NUM), .IW(PORT_SIZE)) u_arb (
      .request(out_req[o]),
      .ptr(out_ptr[o]),
      .grant(g_oh[o]),
      .index(g_idx[o]),
      .valid(g_valid[o])
    );
  end

  always_comb begin
    granted = '0;
    dec = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      granted = granted | g_oh[o];
      for (int d = 0; d < VC_NUM; d++)
        dec[o][d] = g_valid[o] && dvc[g_idx[o]] == VC_SIZE'(d);
    end
  end

  always_comb begin
    read_o = '0;
    vc_sel_o = '0;
    xbar_sel_o = '0;
    valid_o = '0;
    if (!rst)
      for (int p = 0; p < PORT_NUM; p++) begin
        if (granted[p]) begin
          read_o[p] = 1'b1;
          vc_sel_o[p] = win[p];
        end
        if (g_valid[p]) begin
          valid_o[p] = 1'b1;
          xbar_sel_o[p] = g_idx[p];
        end
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        in_ptr[p] <= '0;
        out_ptr[p] <= '0;
        for (int d = 0; d < VC_NUM; d++)
          credit[p][d] <= CW'(BUF_DEPTH);
      end
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (granted[p])
          in_ptr[p] <= (win[p] == VC_SIZE'(VC_NUM - 1))
                       ? '0 : win[p] + 1'b1;
        if (g_valid[p])
          out_ptr[p] <= (g_idx[p] == port_t'(PORT_NUM - 1))
                        ? '0 : g_idx[p] + 1'b1;
        for (int d = 0; d < VC_NUM; d++) begin
          assert (!(credit_i[p][d] && !dec[p][d]
                    && credit[p][d] == CW'(BUF_DEPTH)))
            else $error("credit overflow port %0d vc %0d", p, d);
          unique case ({dec[p][d], credit_i[p][d]})
            2'b10: credit[p][d] <= credit[p][d] - 1'b1;
            2'b01:
              if (credit[p][d] != CW'(BUF_DEPTH))
                credit[p][d] <= credit[p][d] + 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
